// File: rtl/drac_pkg.sv
// Shared types for the D-cache request arbiter: FSM states, response cause
// codes, tag layout and the exception-to-cause mapping.
package drac_pkg;

    // Tag layout: [7:6] requester id, [5:0] sequence number.
    localparam int DMEM_TAG_ID_BITS  = 2;
    localparam int DMEM_TAG_SEQ_BITS = 6;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_ISSUE   = 3'd1,
        ARB_WAIT    = 3'd2,
        ARB_BACKOFF = 3'd3,
        ARB_DRAIN   = 3'd4
    } arb_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_MA_LD   = 3'd1,
        CAUSE_MA_ST   = 3'd2,
        CAUSE_PF_LD   = 3'd3,
        CAUSE_PF_ST   = 3'd4,
        CAUSE_RETRY   = 3'd5,
        CAUSE_TIMEOUT = 3'd6
    } dmem_cause_t;

    // Exception vector is {pf_st, pf_ld, ma_st, ma_ld}; the lowest set bit wins.
    function automatic dmem_cause_t xcpt_cause(input logic [3:0] xcpt);
        dmem_cause_t c;
        c = CAUSE_NONE;
        if (xcpt[0])      c = CAUSE_MA_LD;
        else if (xcpt[1]) c = CAUSE_MA_ST;
        else if (xcpt[2]) c = CAUSE_PF_LD;
        else if (xcpt[3]) c = CAUSE_PF_ST;
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first valid index at or after
// ptr_i, wrapping to index 0. Also usable on the icache side.
module rr_arbiter
    import drac_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          valid_i,
    input  logic [DMEM_TAG_ID_BITS-1:0] ptr_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [DMEM_TAG_ID_BITS-1:0] idx_o,
    output logic                        any_o
);

    logic found;

    // Two passes: indices at/after the pointer first, then the wrapped range.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid_i[i] && (i >= int'(ptr_i))) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = DMEM_TAG_ID_BITS'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = DMEM_TAG_ID_BITS'(i);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dmem_req_arbiter.sv
// Shares the single D-cache request port between NUM_REQ requesters with one
// request in flight. Handles retries with backoff, flush/kill and routes the
// response (or an error) back to the owner.
//
// Handshakes: a requester transfer happens in the cycle where req_valid_i[g]
// and req_ready_o[g] are both high; the cache transfer happens in the cycle
// where dmem_req_valid_o and dmem_req_ready_i are both high. While
// dmem_req_valid_o is high every dmem_req_* field is held stable.
//
// Optional: define DMEM_ARB_TIMEOUT_EN to add a response watchdog of
// TIMEOUT_CYC cycles in WAIT/DRAIN (error cause 6 from WAIT).
module dmem_req_arbiter
    import drac_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_RETRY   = 8,
    parameter int BACKOFF_CYC = 4
`ifdef DMEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*5-1:0]  req_cmd_i,
    input  logic [NUM_REQ*4-1:0]  req_op_type_i,
    input  logic [NUM_REQ*40-1:0] req_addr_i,
    input  logic [NUM_REQ*64-1:0] req_data_i,
    output logic                  dmem_req_valid_o,
    input  logic                  dmem_req_ready_i,
    output logic [4:0]            dmem_req_cmd_o,
    output logic [3:0]            dmem_op_type_o,
    output logic [39:0]           dmem_req_addr_o,
    output logic [63:0]           dmem_req_data_o,
    output logic [7:0]            dmem_req_tag_o,
    output logic                  dmem_req_kill_o,
    input  logic                  dmem_resp_valid_i,
    input  logic                  dmem_resp_nack_i,
    input  logic                  dmem_resp_replay_i,
    input  logic [63:0]           dmem_resp_data_i,
    input  logic [3:0]            dmem_xcpt_i,
    output logic [NUM_REQ-1:0]    resp_valid_o,
    output logic [63:0]           resp_data_o,
    output logic                  resp_err_o,
    output dmem_cause_t           resp_cause_o,
    output logic                  busy_o,
    output arb_state_t            dbg_state_o
);

    localparam int ID_W    = DMEM_TAG_ID_BITS;
    localparam int SEQ_W   = DMEM_TAG_SEQ_BITS;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int BO_W    = $clog2(BACKOFF_CYC + 1);
`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
`endif

    arb_state_t         state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [RETRY_W-1:0] retry_cnt_q;
    logic [BO_W-1:0]    bo_cnt_q;
    logic [NUM_REQ-1:0] own_q;
    logic [ID_W-1:0]    id_q;
    logic [4:0]         cmd_q;
    logic [3:0]         op_q;
    logic [39:0]        addr_q;
    logic [63:0]        data_q;
    logic [7:0]         tag_q;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [63:0]        resp_data_q;
    logic               resp_err_q;
    dmem_cause_t        resp_cause_q;
`ifdef DMEM_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_cnt_q;
`endif

    logic [NUM_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               rsp_event;
    logic               rsp_retry;
    logic [ID_W-1:0]    next_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt_oh),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign rsp_retry = dmem_resp_nack_i | dmem_resp_replay_i;
    assign rsp_event = dmem_resp_valid_i | rsp_retry | (|dmem_xcpt_i);
    assign next_ptr  = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

    // Single FSM: request capture, issue/retry sequencing and response routing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            seq_q        <= '0;
            retry_cnt_q  <= '0;
            bo_cnt_q     <= '0;
            own_q        <= '0;
            id_q         <= '0;
            cmd_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
`ifdef DMEM_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
            case (state_q)
                ARB_IDLE: begin
                    if (gnt_any && !flush_i) begin
                        own_q       <= gnt_oh;
                        id_q        <= gnt_idx;
                        cmd_q       <= req_cmd_i[int'(gnt_idx)*5 +: 5];
                        op_q        <= req_op_type_i[int'(gnt_idx)*4 +: 4];
                        addr_q      <= req_addr_i[int'(gnt_idx)*40 +: 40];
                        data_q      <= req_data_i[int'(gnt_idx)*64 +: 64];
                        tag_q       <= {gnt_idx, seq_q};
                        retry_cnt_q <= '0;
                        state_q     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (dmem_req_ready_i) begin
                        // Handshake completes even under flush; the reply is then drained.
                        seq_q   <= seq_q + 1'b1;
                        state_q <= flush_i ? ARB_DRAIN : ARB_WAIT;
`ifdef DMEM_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end else if (flush_i) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= next_ptr;
                    end
                end
                ARB_WAIT: begin
                    if (rsp_event) begin
                        if (flush_i) begin
                            // Reply arrived together with the flush: drop it silently.
                            state_q  <= ARB_IDLE;
                            rr_ptr_q <= next_ptr;
                        end else if (|dmem_xcpt_i) begin
                            resp_valid_q <= own_q;
                            resp_err_q   <= 1'b1;
                            resp_cause_q <= xcpt_cause(dmem_xcpt_i);
                            state_q      <= ARB_IDLE;
                            rr_ptr_q     <= next_ptr;
                        end else if (rsp_retry) begin
                            if (retry_cnt_q == RETRY_W'(MAX_RETRY - 1)) begin
                                resp_valid_q <= own_q;
                                resp_err_q   <= 1'b1;
                                resp_cause_q <= CAUSE_RETRY;
                                state_q      <= ARB_IDLE;
                                rr_ptr_q     <= next_ptr;
                            end else begin
                                retry_cnt_q <= retry_cnt_q + 1'b1;
                                bo_cnt_q    <= '0;
                                state_q     <= ARB_BACKOFF;
                            end
                        end else begin
                            resp_valid_q <= own_q;
                            resp_data_q  <= dmem_resp_data_i;
                            state_q      <= ARB_IDLE;
                            rr_ptr_q     <= next_ptr;
                        end
                    end else if (flush_i) begin
                        state_q <= ARB_DRAIN;
`ifdef DMEM_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        resp_valid_q <= own_q;
                        resp_err_q   <= 1'b1;
                        resp_cause_q <= CAUSE_TIMEOUT;
                        state_q      <= ARB_IDLE;
                        rr_ptr_q     <= next_ptr;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                ARB_BACKOFF: begin
                    if (flush_i) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= next_ptr;
                    end else if (bo_cnt_q == BO_W'(BACKOFF_CYC - 1)) begin
                        // Re-issue the held fields under a fresh sequence number.
                        tag_q   <= {id_q, seq_q};
                        state_q <= ARB_ISSUE;
                    end else begin
                        bo_cnt_q <= bo_cnt_q + 1'b1;
                    end
                end
                ARB_DRAIN: begin
                    if (rsp_event) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= next_ptr;
`ifdef DMEM_ARB_TIMEOUT_EN
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= next_ptr;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Accept pulse and kill are same-cycle answers to the current inputs.
    assign req_ready_o      = (state_q == ARB_IDLE && !flush_i && !rst_i) ? gnt_oh : '0;
    assign dmem_req_kill_o  = (state_q == ARB_WAIT) && flush_i && !rsp_event && !rst_i;
    assign dmem_req_valid_o = (state_q == ARB_ISSUE);
    assign dmem_req_cmd_o   = cmd_q;
    assign dmem_op_type_o   = op_q;
    assign dmem_req_addr_o  = addr_q;
    assign dmem_req_data_o  = data_q;
    assign dmem_req_tag_o   = tag_q;
    assign resp_valid_o     = resp_valid_q;
    assign resp_data_o      = resp_data_q;
    assign resp_err_o       = resp_err_q;
    assign resp_cause_o     = resp_cause_q;
    assign busy_o           = (state_q != ARB_IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: doc/dmem_req_arbiter.md
Name: dmem_req_arbiter

Overview:
Shares the single D-cache request port between NUM_REQ requesters, for example the LSU, the debug register/memory port and a future PTW walker. Only one request is in flight at a time.
- Selects the next requester round-robin.
- Holds the granted request stable until the cache accepts it.
- Tracks the outstanding request by tag.
- Re-issues the request on nack or replay, with a bounded retry count and backoff.
- Routes the response, or an error, back to the owning requester.

Sits between the datapath request sources and dcache_interface, in place of the direct req_cpu_dcache connection.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
MAX_RETRY, 8, nacks/replays tolerated before an error is returned
BACKOFF_CYC, 4, idle cycles between a nack and the re-issue (>=1)
TIMEOUT_CYC, 1024, response watchdog limit (optional feature only)

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush; abort or kill the current request
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  one-hot accept pulse
req_cmd_i  in  NUM_REQ*5  memory command per requester
req_op_type_i  in  NUM_REQ*4  access size/sign per requester
req_addr_i  in  NUM_REQ*40  address per requester
req_data_i  in  NUM_REQ*64  store data per requester
dmem_req_valid_o  out  1  cache request valid
dmem_req_ready_i  in  1  cache request ready
dmem_req_cmd_o  out  5  held command
dmem_op_type_o  out  4  held op type
dmem_req_addr_o  out  40  held address
dmem_req_data_o  out  64  held data
dmem_req_tag_o  out  8  tag: [7:6] requester id, [5:0] sequence number
dmem_req_kill_o  out  1  one-cycle kill of the in-flight request
dmem_resp_valid_i  in  1  cache response valid
dmem_resp_nack_i  in  1  request rejected
dmem_resp_replay_i  in  1  request must be replayed
dmem_resp_data_i  in  64  load data
dmem_xcpt_i  in  4  {pf_st, pf_ld, ma_st, ma_ld}
resp_valid_o  out  NUM_REQ  one-hot response pulse to the owner
resp_data_o  out  64  response data
resp_err_o  out  1  response carries an error
resp_cause_o  out  3  0 none, 1 ma_ld, 2 ma_st, 3 pf_ld, 4 pf_st, 5 retry exhausted, 6 timeout
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, rr_ptr=0, seq=0, retry_cnt=0.
  - All outputs 0.
  - Reset overrides every in-flight condition; no response is produced for an aborted request.
- States: IDLE, ISSUE, WAIT, BACKOFF, DRAIN.
- IDLE:
  - With any req_valid_i set and flush_i low, grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Pulse req_ready_o[g] in that cycle and latch cmd/op/addr/data/g.
  - retry_cnt=0; next state ISSUE, so dmem_req_valid_o rises the next cycle.
- ISSUE:
  - dmem_req_valid_o=1; all dmem_req_* held stable until dmem_req_ready_i.
  - On the handshake: tag={g,seq}, seq+=1 (wraps 63->0), next state WAIT.
- WAIT, in priority order on the cycle a response event arrives:
  1. Any dmem_xcpt_i bit set: resp_err_o=1, cause = lowest set bit mapped to codes 1..4; go to IDLE.
  2. dmem_resp_nack_i or dmem_resp_replay_i:
     - If retry_cnt==MAX_RETRY-1: error with cause 5, go to IDLE.
     - Otherwise retry_cnt+=1, go to BACKOFF.
  3. dmem_resp_valid_i alone: resp_valid_o[g]=1 for one cycle with resp_data_o and resp_err_o=0; go to IDLE.
  - Any response (good or error) sets rr_ptr=(g+1)%NUM_REQ.
  - Error responses also pulse resp_valid_o[g]; resp_data_o=0.
- BACKOFF: count BACKOFF_CYC cycles, then go to ISSUE with the same held fields and a new seq.
- flush_i handling:
  - IDLE: no grant.
  - ISSUE without handshake: drop the request, go to IDLE.
  - ISSUE with handshake in the same cycle: the handshake completes, go to DRAIN.
  - WAIT: dmem_req_kill_o=1 for that cycle, go to DRAIN.
  - BACKOFF: go to IDLE.
  - DRAIN: ignored.
- DRAIN:
  - Wait for the next dmem_resp_valid_i, nack, replay or exception; discard it, issue no resp_valid_o, go to IDLE.
  - rr_ptr is still advanced.
- A flushed request produces no response to its requester.
- Response events outside WAIT/DRAIN are ignored.

Optional Feature:
DMEM_ARB_TIMEOUT_EN
- Defined:
  - A TIMEOUT_CYC counter clears on entry to WAIT/DRAIN and increments each cycle spent there.
  - Reaching TIMEOUT_CYC in WAIT: error with cause 6, go to IDLE.
  - Reaching TIMEOUT_CYC in DRAIN: silently go to IDLE.
- Undefined: no counter is present, waits are unbounded and cause 6 never occurs.

Decomposition:
- drac_pkg receives:
  - typedef arb_state_t;
  - typedef dmem_cause_t (3-bit) with enumerated codes;
  - constant DMEM_TAG_ID_BITS=2.
- Sub-module rr_arbiter (NUM_REQ param; inputs valid vector and pointer; output one-hot grant plus index). Combinational and reusable by the icache side.

Test Plan:
- Single request on requester 0 (load, addr 0x80000040); cache ready immediately; response 3 cycles later with data 0xDEADBEEF -> req_ready_o=01 at T, dmem_req_valid_o at T+1, tag=0x00, resp_valid_o=01 with 0xDEADBEEF, busy_o back to 0.
- Both requesters held valid for 4 back-to-back transactions -> grants alternate 0,1,0,1; tags 0x00,0x41,0x02,0x43.
- Nack on every attempt with MAX_RETRY=8 -> exactly 8 issues, each separated by >=BACKOFF_CYC idle cycles; then resp_err_o=1, cause=5.
- dmem_req_ready_i held low 10 cycles, with flush_i pulsed at cycle 5 -> valid drops, no response; with flush_i instead in WAIT -> kill pulsed once, the late response is discarded, the next grant proceeds.
- dmem_xcpt_i=0100 (pf_ld) in WAIT -> cause=3, err=1; rst_i asserted mid-WAIT -> all outputs 0 next cycle and the following grant uses tag seq 0.
- With DMEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no response -> cause=6 exactly 16 cycles after entering WAIT.
